// File: rtl/pio_cfg_sequencer.sv
// Configuration sequencer for one pio instance: loads a program, sets wrap/div/pins/side-set,
// enables the machine, then round-robin arbitrates two TX-FIFO push requesters onto the bus.
module pio_cfg_sequencer #(
  parameter int unsigned CMD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  cfg_mindex,
  input  logic [5:0]  cfg_plen,
  input  logic [23:0] cfg_div,
  input  logic [31:0] cfg_pins,
  input  logic [4:0]  cfg_side,
  output logic [4:0]  prog_addr,
  input  logic [15:0] prog_data,
  input  logic [1:0]  tx_valid,
  input  logic [31:0] tx_data0,
  input  logic [31:0] tx_data1,
  output logic [1:0]  tx_ready,
  output logic [3:0]  action,
  output logic [4:0]  index,
  output logic [1:0]  mindex,
  output logic [31:0] din,
  output logic        busy,
  output logic        running
);

  localparam logic [3:0] ActIdle  = 4'd0;
  localparam logic [3:0] ActInstr = 4'd1;
  localparam logic [3:0] ActWrap  = 4'd2;
  localparam logic [3:0] ActPush  = 4'd4;
  localparam logic [3:0] ActPins  = 4'd5;
  localparam logic [3:0] ActEn    = 4'd6;
  localparam logic [3:0] ActDiv   = 4'd7;
  localparam logic [3:0] ActSide  = 4'd8;
  localparam logic [3:0] CntLast  = 4'(CMD_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle, StFetch, StWrite, StWrap, StDiv, StPins, StSide, StEn, StRun, StDis
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  k_q, k_d;
  logic [5:0]  plen_q, plen_d;
  logic [1:0]  mi_q, mi_d;
  logic [23:0] div_q, div_d;
  logic [31:0] pins_q, pins_d;
  logic [4:0]  side_q, side_d;
  logic [15:0] word_q, word_d;
  logic        ptr_q, ptr_d;
  logic        gnt_q, gnt_d;

  logic [3:0]  action_q, action_d;
  logic [4:0]  index_q, index_d;
  logic [1:0]  mindex_q, mindex_d;
  logic [31:0] din_q, din_d;
  logic [4:0]  prog_addr_q, prog_addr_d;
  logic [1:0]  tx_ready_q, tx_ready_d;
  logic        busy_q, busy_d;
  logic        running_q, running_d;

  logic [5:0]  plen_c;
  logic        cmd_done;
  logic        win;
  logic [31:0] push_data;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    plen_d    = plen_q;
    mi_d      = mi_q;
    div_d     = div_q;
    pins_d    = pins_q;
    side_d    = side_q;
    word_d    = word_q;
    ptr_d     = ptr_q;
    gnt_d     = 1'b0;
    plen_c    = (cfg_plen > 6'd32) ? 6'd32 : cfg_plen;
    cmd_done  = (cnt_q == CntLast);
    // Pointer only matters when both requesters contend.
    win       = (tx_valid == 2'b11) ? ptr_q : tx_valid[1];
    push_data = win ? tx_data1 : tx_data0;

    case (state_q)
      StIdle: begin
        if (start) begin
          plen_d  = plen_c;
          mi_d    = cfg_mindex;
          div_d   = cfg_div;
          pins_d  = cfg_pins;
          side_d  = cfg_side;
          ptr_d   = 1'b0;
          k_d     = 5'd0;
          cnt_d   = 4'd0;
          state_d = (plen_c == 6'd0) ? StWrap : StFetch;
        end
      end
      StFetch: begin
        word_d  = prog_data;
        cnt_d   = 4'd0;
        state_d = StWrite;
      end
      StWrite: begin
        if (cmd_done) begin
          cnt_d = 4'd0;
          if (({1'b0, k_q} + 6'd1) == plen_q) begin
            state_d = StWrap;
          end else begin
            k_d     = k_q + 5'd1;
            state_d = StFetch;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StWrap, StDiv, StPins, StSide, StEn, StDis: begin
        if (cmd_done) begin
          cnt_d = 4'd0;
          case (state_q)
            StWrap:  state_d = StDiv;
            StDiv:   state_d = StPins;
            StPins:  state_d = StSide;
            StSide:  state_d = StEn;
            StEn:    state_d = StRun;
            default: state_d = StIdle;
          endcase
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRun: begin
        // The cycle after a grant is forced idle: no grant and no stop.
        if (!gnt_q) begin
          if (stop) begin
            state_d = StDis;
            cnt_d   = 4'd0;
          end else if (|tx_valid) begin
            gnt_d = 1'b1;
            ptr_d = ~win;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    action_d    = ActIdle;
    index_d     = 5'd0;
    mindex_d    = 2'd0;
    din_d       = 32'd0;
    prog_addr_d = 5'd0;
    tx_ready_d  = 2'b00;
    busy_d      = (state_d != StIdle);
    running_d   = (state_d == StRun);

    case (state_d)
      StFetch: prog_addr_d = k_d;
      StWrite: begin
        prog_addr_d = k_d;
        action_d    = ActInstr;
        index_d     = k_d;
        din_d       = {16'h0, word_d};
      end
      StWrap: begin
        action_d = ActWrap;
        mindex_d = mi_d;
        index_d  = (plen_d == 6'd0) ? 5'd0 : 5'(plen_d - 6'd1);
      end
      StDiv: begin
        action_d = ActDiv;
        mindex_d = mi_d;
        din_d    = {8'h0, div_d};
      end
      StPins: begin
        action_d = ActPins;
        mindex_d = mi_d;
        din_d    = pins_d;
      end
      StSide: begin
        action_d = ActSide;
        mindex_d = mi_d;
        din_d    = {27'h0, side_d};
      end
      StEn: begin
        action_d = ActEn;
        mindex_d = mi_d;
        din_d    = 32'd1 << mi_d;
      end
      StRun: begin
        mindex_d = mi_d;
        if (gnt_d) begin
          action_d   = ActPush;
          din_d      = push_data;
          tx_ready_d = win ? 2'b10 : 2'b01;
        end
      end
      StDis: begin
        action_d = ActEn;
        mindex_d = mi_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      k_q         <= 5'd0;
      plen_q      <= 6'd0;
      mi_q        <= 2'd0;
      div_q       <= 24'd0;
      pins_q      <= 32'd0;
      side_q      <= 5'd0;
      word_q      <= 16'd0;
      ptr_q       <= 1'b0;
      gnt_q       <= 1'b0;
      action_q    <= 4'd0;
      index_q     <= 5'd0;
      mindex_q    <= 2'd0;
      din_q       <= 32'd0;
      prog_addr_q <= 5'd0;
      tx_ready_q  <= 2'b00;
      busy_q      <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      plen_q      <= plen_d;
      mi_q        <= mi_d;
      div_q       <= div_d;
      pins_q      <= pins_d;
      side_q      <= side_d;
      word_q      <= word_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      action_q    <= action_d;
      index_q     <= index_d;
      mindex_q    <= mindex_d;
      din_q       <= din_d;
      prog_addr_q <= prog_addr_d;
      tx_ready_q  <= tx_ready_d;
      busy_q      <= busy_d;
      running_q   <= running_d;
    end
  end

  assign action    = action_q;
  assign index     = index_q;
  assign mindex    = mindex_q;
  assign din       = din_q;
  assign prog_addr = prog_addr_q;
  assign tx_ready  = tx_ready_q;
  assign busy      = busy_q;
  assign running   = running_q;

endmodule

// File: tb/tb_pio_cfg_sequencer.sv
// Directed bench for pio_cfg_sequencer: configuration bus traces, clamping, latching,
// round-robin pushes, stop priority and mid-sequence reset.
module tb_pio_cfg_sequencer;

  localparam int C = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  cfg_mindex = '0;
  logic [5:0]  cfg_plen = '0;
  logic [23:0] cfg_div = '0;
  logic [31:0] cfg_pins = '0;
  logic [4:0]  cfg_side = '0;
  logic [4:0]  prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  tx_valid = '0;
  logic [31:0] tx_data0 = '0;
  logic [31:0] tx_data1 = '0;
  logic [1:0]  tx_ready;
  logic [3:0]  action;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic [31:0] din;
  logic        busy;
  logic        running;

  logic [15:0] mem [0:31];
  assign prog_data = mem[prog_addr];

  always #5 clk = ~clk;

  pio_cfg_sequencer #(.CMD_CYCLES(C)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_mindex(cfg_mindex), .cfg_plen(cfg_plen), .cfg_div(cfg_div),
    .cfg_pins(cfg_pins), .cfg_side(cfg_side),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .tx_valid(tx_valid), .tx_data0(tx_data0), .tx_data1(tx_data1), .tx_ready(tx_ready),
    .action(action), .index(index), .mindex(mindex), .din(din),
    .busy(busy), .running(running)
  );

  int total = 0;
  int bad = 0;

  logic [3:0]  e_act [$];
  logic [4:0]  e_idx [$];
  logic [31:0] e_din [$];
  int          e_pa  [$];
  bit          e_mchk [$];
  logic [1:0]  e_mi;

  task automatic push_exp(input logic [3:0] a, input logic [4:0] ix, input logic [31:0] d,
                          input int pa, input bit mchk, input int n);
    for (int j = 0; j < n; j++) begin
      e_act.push_back(a);
      e_idx.push_back(ix);
      e_din.push_back(d);
      e_pa.push_back(pa);
      e_mchk.push_back(mchk);
    end
  endtask

  task automatic build_expect(input int plen_eff, input logic [1:0] mi, input logic [23:0] dv,
                              input logic [31:0] pn, input logic [4:0] sd);
    e_act.delete(); e_idx.delete(); e_din.delete(); e_pa.delete(); e_mchk.delete();
    e_mi = mi;
    for (int k = 0; k < plen_eff; k++) begin
      push_exp(4'd0, 5'd0, 32'd0, k, 1'b0, 1);
      push_exp(4'd1, 5'(k), {16'h0, mem[k]}, -1, 1'b0, C);
    end
    push_exp(4'd2, (plen_eff == 0) ? 5'd0 : 5'(plen_eff - 1), 32'd0, -1, 1'b1, C);
    push_exp(4'd7, 5'd0, {8'h0, dv}, -1, 1'b1, C);
    push_exp(4'd5, 5'd0, pn, -1, 1'b1, C);
    push_exp(4'd8, 5'd0, {27'h0, sd}, -1, 1'b1, C);
    push_exp(4'd6, 5'd0, 32'd1 << mi, -1, 1'b1, C);
  endtask

  task automatic set_cfg(input logic [5:0] pl, input logic [1:0] mi, input logic [23:0] dv,
                         input logic [31:0] pn, input logic [4:0] sd);
    cfg_plen = pl; cfg_mindex = mi; cfg_div = dv; cfg_pins = pn; cfg_side = sd;
  endtask

  task automatic load_prog();
    mem[0] = 16'h9020; mem[1] = 16'hE727; mem[2] = 16'h6001; mem[3] = 16'h0642;
  endtask

  // Pulses start from IDLE and walks the expected trace; optional injected start/stop
  // during the sequence, optional reset at a given cycle (returns with reset held low).
  task automatic drive_and_trace(input string name, input int start_at, input int rst_at);
    logic [44:0] obs, want;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    set_cfg(6'd7, 2'd3, 24'hFFFFFF, 32'hA5A5A5A5, 5'd31);
    for (int i = 0; i < e_act.size(); i++) begin
      obs  = {action, index, din, busy, running, tx_ready};
      want = {e_act[i], e_idx[i], e_din[i], 1'b1, 1'b0, 2'b00};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL %s bus cyc=%0d got=%h want=%h", name, i, obs, want);
      end
      if (e_pa[i] >= 0) begin
        total++;
        if (prog_addr !== 5'(e_pa[i])) begin
          bad++;
          $display("FAIL %s prog_addr cyc=%0d got=%0d want=%0d", name, i, prog_addr, e_pa[i]);
        end
      end
      if (e_mchk[i]) begin
        total++;
        if (mindex !== e_mi) begin
          bad++;
          $display("FAIL %s mindex cyc=%0d got=%0d want=%0d", name, i, mindex, e_mi);
        end
      end
      if (i == rst_at) begin
        reset = 1'b0;
        #1;
        total++;
        if ({action, index, mindex, din, prog_addr, tx_ready, busy, running} !== '0) begin
          bad++;
          $display("FAIL %s async_reset got act=%0d busy=%b din=%h want all zero",
                   name, action, busy, din);
        end
        return;
      end
      start = (i == start_at);
      stop  = (i == start_at);
      @(negedge clk);
    end
    start = 1'b0;
    stop  = 1'b0;
    total++;
    if (running !== 1'b1 || busy !== 1'b1 || action !== 4'd0) begin
      bad++;
      $display("FAIL %s run_entry got running=%b busy=%b act=%0d want 1 1 0",
               name, running, busy, action);
    end
  endtask

  task automatic go_idle(input string name);
    int n;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy !== 1'b0 || action !== 4'd0 || running !== 1'b0) begin
      bad++;
      $display("FAIL %s go_idle got busy=%b act=%0d want busy=0 act=0", name, busy, action);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({action, index, mindex, din, prog_addr, tx_ready, busy, running} !== '0) begin
      bad++;
      $display("FAIL reset_hold got act=%0d busy=%b want all zero", action, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({action, index, mindex, din, prog_addr, tx_ready, busy, running} !== '0) begin
      bad++;
      $display("FAIL reset_idle got act=%0d busy=%b want all zero", action, busy);
    end
  endtask

  task automatic test_program();
    load_prog();
    set_cfg(6'd4, 2'd0, 24'd0, 32'h01000001, 5'd1);
    build_expect(4, 2'd0, 24'd0, 32'h01000001, 5'd1);
    total++;
    if (e_act.size() != 22) begin
      bad++;
      $display("FAIL program cfg_len got=%0d want=22", e_act.size());
    end
    drive_and_trace("program", -1, -1);
  endtask

  task automatic test_back_to_back();
    logic [44:0] obs, want;
    tx_data0 = 32'h30;
    tx_data1 = 32'h31;
    tx_valid = 2'b11;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j % 2 == 0) begin
        want = {4'd4, 5'd0, (j % 4 == 0) ? 32'h30 : 32'h31, 1'b1, 1'b1,
                (j % 4 == 0) ? 2'b01 : 2'b10};
      end else begin
        want = {4'd0, 5'd0, 32'd0, 1'b1, 1'b1, 2'b00};
      end
      obs = {action, index, din, busy, running, tx_ready};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d got=%h want=%h", j, obs, want);
      end
    end
    tx_valid = 2'b00;
    @(negedge clk);
    total++;
    if (action !== 4'd0 || tx_ready !== 2'b00) begin
      bad++;
      $display("FAIL back_to_back drain got act=%0d rdy=%b want 0 00", action, tx_ready);
    end
  endtask

  task automatic test_stop_priority();
    logic [44:0] obs, want;
    stop = 1'b1;
    tx_valid = 2'b01;
    tx_data0 = 32'h55;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      stop = 1'b0;
      tx_valid = 2'b00;
      want = (j < 2) ? {4'd6, 5'd0, 32'd0, 1'b1, 1'b0, 2'b00} : 45'd0;
      obs = {action, index, din, busy, running, tx_ready};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL stop_priority cyc=%0d got=%h want=%h", j, obs, want);
      end
    end
  endtask

  task automatic test_plen_zero();
    set_cfg(6'd0, 2'd1, 24'h000100, 32'h0000FF00, 5'd2);
    build_expect(0, 2'd1, 24'h000100, 32'h0000FF00, 5'd2);
    drive_and_trace("plen_zero", -1, -1);
    go_idle("plen_zero");
  endtask

  task automatic test_plen_clamp();
    for (int i = 0; i < 32; i++) mem[i] = 16'hA000 + 16'(i * 3);
    set_cfg(6'd40, 2'd2, 24'h123456, 32'hDEADBEEF, 5'd17);
    build_expect(32, 2'd2, 24'h123456, 32'hDEADBEEF, 5'd17);
    drive_and_trace("plen_clamp", -1, -1);
    go_idle("plen_clamp");
  endtask

  task automatic test_start_ignored();
    load_prog();
    set_cfg(6'd4, 2'd0, 24'd0, 32'h01000001, 5'd1);
    build_expect(4, 2'd0, 24'd0, 32'h01000001, 5'd1);
    drive_and_trace("start_ignored", 2, -1);
    go_idle("start_ignored");
  endtask

  task automatic test_reset_mid();
    load_prog();
    set_cfg(6'd4, 2'd0, 24'd0, 32'h01000001, 5'd1);
    build_expect(4, 2'd0, 24'd0, 32'h01000001, 5'd1);
    drive_and_trace("reset_mid", -1, 16);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || action !== 4'd0) begin
      bad++;
      $display("FAIL reset_mid post got busy=%b act=%0d want 0 0", busy, action);
    end
    set_cfg(6'd4, 2'd0, 24'd0, 32'h01000001, 5'd1);
    drive_and_trace("reset_replay", -1, -1);
    go_idle("reset_replay");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h0;
    test_reset();
    test_program();
    test_back_to_back();
    test_stop_priority();
    test_plen_zero();
    test_plen_clamp();
    test_start_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
